// File: rtl/cnt_pkg.sv
// Shared encodings for the up/down counter: count mode and direction of travel.
package cnt_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/cnt_psc.sv
// Prescaler: emits a one-cycle tick on every PSC-th enabled cycle.
module cnt_psc #(
  parameter int PSC = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int PW = (PSC > 1) ? $clog2(PSC) : 1;
  localparam logic [PW-1:0] LAST = PW'(PSC - 1);

  logic [PW-1:0] phase_q, phase_d;

  // Phase only advances on enabled cycles, so a disabled cycle freezes it.
  always_comb begin
    o_tick  = i_en && (phase_q == LAST);
    phase_d = phase_q;
    if (i_clr) begin
      phase_d = '0;
    end else if (i_en) begin
      phase_d = o_tick ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/updn_cnt.sv
// Bounded up/down counter with prescaler, wrap or saturate at the bounds,
// clamped synchronous load, registered terminal-count pulse and saturation flag.
module updn_cnt
  import cnt_pkg::*;
#(
  parameter int UPBND = 15,
  parameter int LOBND = 0,
  parameter int PSC   = 1,
  parameter int CW    = $clog2(UPBND + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_dir,
  input  logic          i_mode,
  input  logic          i_load,
  input  logic [CW-1:0] i_ld_val,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc,
  output logic          o_sat
);

  localparam logic [CW-1:0] UP = CW'(UPBND);
  localparam logic [CW-1:0] LO = CW'(LOBND);

  cnt_mode_e     mode;
  cnt_dir_e      dir;
  logic          tick;
  logic [CW-1:0] bound;
  logic [CW-1:0] ld_clamped;
  logic [CW:0]   below_diff;
  logic [CW:0]   above_diff;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc_q, tc_d;
  logic          sat_q, sat_d;

  cnt_psc #(
    .PSC (PSC)
  ) u_psc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_clr  (i_load),
    .o_tick (tick)
  );

  always_comb begin
    mode  = cnt_mode_e'(i_mode);
    dir   = cnt_dir_e'(i_dir);
    bound = (dir == DIR_UP) ? UP : LO;

    // Borrow bits of the extended differences give the clamp decisions
    // without comparisons that fold to constants for edge bounds.
    below_diff = {1'b0, i_ld_val} - {1'b0, LO};
    above_diff = {1'b0, UP} - {1'b0, i_ld_val};
    if (below_diff[CW]) begin
      ld_clamped = LO;
    end else if (above_diff[CW]) begin
      ld_clamped = UP;
    end else begin
      ld_clamped = i_ld_val;
    end

    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (i_load) begin
      cnt_d = ld_clamped;
    end else if (tick) begin
      if (cnt_q != bound) begin
        cnt_d = (dir == DIR_UP) ? cnt_q + CW'(1) : cnt_q - CW'(1);
        tc_d  = (mode == MODE_SAT) && (cnt_d == bound);
      end else if (mode == MODE_WRAP) begin
        cnt_d = (dir == DIR_UP) ? LO : UP;
        tc_d  = 1'b1;
      end else begin
        // Holding at the bound pulses only when saturation is newly entered.
        tc_d = ~sat_q;
      end
    end

    sat_d = (mode == MODE_SAT) && (cnt_d == bound);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= LO;
      tc_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      sat_q <= sat_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_tc  = tc_q;
  assign o_sat = sat_q;

endmodule
